// File: rtl/quad_pkg.sv
// Shared quadrature phase encoding and step functions; also used by the decoder bench.
package quad_pkg;

    localparam int unsigned CMD_W = 32;
    localparam logic [CMD_W-1:0] CMD_MAX_MAG = 32'h7FFF_FFFF;
    localparam logic [CMD_W-1:0] CMD_MIN_NEG = 32'h8000_0000;

    // Bit 1 is channel A, bit 0 is channel B.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S10 = 2'b10,
        S11 = 2'b11,
        S01 = 2'b01
    } phase_e;

    function automatic phase_e next_state_fwd(input phase_e s);
        case (s)
            S00:     return S10;
            S10:     return S11;
            S11:     return S01;
            default: return S00;
        endcase
    endfunction

    function automatic phase_e next_state_rev(input phase_e s);
        case (s)
            S00:     return S01;
            S01:     return S11;
            S11:     return S10;
            default: return S00;
        endcase
    endfunction

endpackage

// File: rtl/quad_edge_timer.sv
// Edge interval timer: turns a signed rate command into a 1-clk edge strobe every |cmd| clks.
module quad_edge_timer
    import quad_pkg::*;
#(
    parameter int unsigned MIN_EDGE_CLKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CMD_W-1:0] cmd,
    output logic             edge_stb
);

    localparam logic [CMD_W-1:0] MIN_CLKS = CMD_W'(MIN_EDGE_CLKS);

    logic [CMD_W-1:0] mag;
    logic [CMD_W-1:0] cnt_q;
    logic [CMD_W-1:0] cnt_d;

    always_comb begin
        mag = cmd[CMD_W-1] ? (~cmd + CMD_W'(1)) : cmd;
        // Negating the most negative command wraps back onto itself; saturate instead.
        if (cmd == CMD_MIN_NEG) begin
            mag = CMD_MAX_MAG;
        end
        if ((mag != '0) && (mag < MIN_CLKS)) begin
            mag = MIN_CLKS;
        end
    end

    always_comb begin
        cnt_d    = '0;
        edge_stb = 1'b0;
        if (enable && (mag != '0)) begin
            if (cnt_q >= (mag - CMD_W'(1))) begin
                edge_stb = 1'b1;
            end else begin
                cnt_d = cnt_q + CMD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/joint_quadgen.sv
// Quadrature A/B/Z encoder emulator driven by a signed joint rate command.
module joint_quadgen
    import quad_pkg::*;
#(
    parameter int unsigned BITS          = 32,
    parameter int unsigned MIN_EDGE_CLKS = 4,
    parameter int unsigned CPR           = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jointEnable,
    input  logic [CMD_W-1:0] jointFreqCmd,
    output logic [BITS-1:0]  jointFeedback,
    output logic             quadA,
    output logic             quadB,
    output logic             quadZ
);

    localparam int unsigned RW = (CPR > 1) ? $clog2(CPR) : 1;
    localparam logic [RW-1:0] REV_MAX = RW'(CPR - 1);

    logic            edge_stb;
    logic            fwd;
    phase_e          state_q, state_d;
    logic [BITS-1:0] fb_q, fb_d;
    logic [RW-1:0]   rev_q, rev_d;
    logic            z_q, z_d;

    quad_edge_timer #(
        .MIN_EDGE_CLKS (MIN_EDGE_CLKS)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (jointEnable),
        .cmd      (jointFreqCmd),
        .edge_stb (edge_stb)
    );

    // Direction is taken from the live command on the edge cycle so a sign flip back-steps at once.
    assign fwd = !jointFreqCmd[CMD_W-1] && (jointFreqCmd != '0);

    always_comb begin
        state_d = state_q;
        fb_d    = fb_q;
        rev_d   = rev_q;
        z_d     = z_q;
        if (edge_stb) begin
            if (fwd) begin
                state_d = next_state_fwd(state_q);
                fb_d    = fb_q + BITS'(1);
                rev_d   = (rev_q == REV_MAX) ? '0 : rev_q + RW'(1);
            end else begin
                state_d = next_state_rev(state_q);
                fb_d    = fb_q - BITS'(1);
                rev_d   = (rev_q == '0) ? REV_MAX : rev_q - RW'(1);
            end
            z_d = (rev_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S00;
            fb_q    <= '0;
            rev_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fb_q    <= fb_d;
            rev_q   <= rev_d;
            z_q     <= z_d;
        end
    end

    assign quadA         = state_q[1];
    assign quadB         = state_q[0];
    assign quadZ         = z_q;
    assign jointFeedback = fb_q;

endmodule

// File: tb/tb_joint_quadgen.sv
// Self-checking bench for joint_quadgen against a position-based behavioural model.
module tb_joint_quadgen;

    localparam int unsigned BITS = 32;
    localparam int unsigned MINE = 4;
    localparam int unsigned CPR  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            jointEnable = 1'b0;
    logic [31:0]     jointFreqCmd = '0;
    logic [BITS-1:0] jointFeedback;
    logic            quadA, quadB, quadZ;

    always #5 clk = ~clk;

    joint_quadgen #(
        .BITS          (BITS),
        .MIN_EDGE_CLKS (MINE),
        .CPR           (CPR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jointEnable   (jointEnable),
        .jointFreqCmd  (jointFreqCmd),
        .jointFeedback (jointFeedback),
        .quadA         (quadA),
        .quadB         (quadB),
        .quadZ         (quadZ)
    );

    int     vectors = 0;
    int     errors  = 0;
    longint pos     = 0;   // model position in edges since reset
    longint el      = 0;   // model clocks elapsed in current interval
    bit     m_z     = 1'b0;
    int     edges   = 0;   // model edges since last reset
    int     dut_zr  = 0;   // DUT Z rising edges since last reset
    logic   prev_z  = 1'b0;

    function automatic longint mag_of(input logic [31:0] c);
        longint v;
        v = longint'(signed'(c));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        if (v != 0 && v < MINE) v = MINE;
        return v;
    endfunction

    // Encoder phase is a function of position only: 00,10,11,01 repeating forward.
    function automatic logic [1:0] ab_of(input longint p);
        longint m;
        m = ((p % 4) + 4) % 4;
        case (m)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        longint n;
        bit     fire;
        bit     dir;
        n    = mag_of(jointFreqCmd);
        fire = 1'b0;
        dir  = (signed'(jointFreqCmd) > 0);
        if (jointEnable && n != 0) begin
            if (el >= n - 1) begin
                fire = 1'b1;
                el   = 0;
            end else begin
                el++;
            end
        end else begin
            el = 0;
        end
        @(posedge clk);
        #1;
        if (fire) begin
            pos = dir ? pos + 1 : pos - 1;
            edges++;
            m_z = (((pos % CPR) + CPR) % CPR) == 0;
        end
        check("outputs", {29'd0, quadA, quadB, quadZ, jointFeedback},
              {29'd0, ab_of(pos), m_z, BITS'(pos)});
        if (quadZ && !prev_z) dut_zr++;
        prev_z = quadZ;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic [31:0] cmd, input logic en);
        rst_n        = 1'b0;
        jointFreqCmd = cmd;
        jointEnable  = en;
        pos = 0; el = 0; m_z = 1'b0; edges = 0; dut_zr = 0; prev_z = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_out", {29'd0, quadA, quadB, quadZ, jointFeedback}, 64'd0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with a live command, then first edge exactly 10 clks after release.
        do_reset(32'd10, 1'b1);
        ticks(9);
        check("first_edge_early", 64'(edges), 64'd0);
        tick();
        check("first_edge_cnt", 64'(edges), 64'd1);
        check("first_edge_ab", {62'd0, quadA, quadB}, 64'b10);

        // Forward steady: 10 edges in 80 clks.
        do_reset(32'd8, 1'b1);
        ticks(80);
        check("fwd_edges", 64'(edges), 64'd10);
        check("fwd_fb", 64'(jointFeedback), 64'd10);

        // Clamp: cmd=+1 behaves as spacing 4.
        do_reset(32'd1, 1'b1);
        ticks(40);
        check("clamp_edges", 64'(edges), 64'd10);

        // Most negative command saturates; no edge and no zero-speed aliasing.
        do_reset(32'h8000_0000, 1'b1);
        ticks(1000);
        check("sat_edges", 64'(edges), 64'd0);
        check("sat_fb", 64'(jointFeedback), 64'd0);

        // Reversal mid-interval back-steps on the next clk.
        do_reset(32'd20, 1'b1);
        ticks(12);
        jointFreqCmd = -32'sd5;
        tick();
        check("rev_fb", 64'(jointFeedback), 64'(32'hFFFF_FFFF));
        check("rev_ab", {62'd0, quadA, quadB}, 64'b01);
        ticks(5);
        check("rev_fb2", 64'(jointFeedback), 64'(32'hFFFF_FFFE));

        // Disable mid-interval freezes and restarts the interval.
        do_reset(32'd8, 1'b1);
        ticks(6);
        jointEnable = 1'b0;
        ticks(10);
        check("dis_edges", 64'(edges), 64'd0);
        jointEnable = 1'b1;
        ticks(7);
        check("reen_early", 64'(edges), 64'd0);
        tick();
        check("reen_edge", 64'(edges), 64'd1);

        // Zero command mid-interval behaves like disable.
        do_reset(32'd8, 1'b1);
        ticks(6);
        jointFreqCmd = '0;
        ticks(10);
        check("zero_edges", 64'(edges), 64'd0);
        jointFreqCmd = 32'd8;
        ticks(8);
        check("zero_resume", 64'(edges), 64'd1);

        // Index: 64 forward edges then 64 reverse edges with CPR=8.
        do_reset(32'd4, 1'b1);
        ticks(256);
        check("idx_fb", 64'(jointFeedback), 64'd64);
        check("idx_z", 64'(dut_zr), 64'd8);
        jointFreqCmd = -32'sd4;
        ticks(256);
        check("idx_back_fb", 64'(jointFeedback), 64'd0);
        check("idx_back_z", 64'(dut_zr), 64'd16);

        // Randomized command/enable segments against the model.
        do_reset(32'd0, 1'b0);
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 7))
                0: jointFreqCmd = '0;
                1: jointFreqCmd = 32'($urandom_range(1, 12));
                2: jointFreqCmd = -32'($urandom_range(1, 12));
                3: jointFreqCmd = 32'h8000_0000;
                4: jointFreqCmd = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 3))
                                                               : -32'($urandom_range(1, 3));
                5: jointFreqCmd = 32'($urandom_range(5, 30));
                default: jointFreqCmd = -32'($urandom_range(4, 30));
            endcase
            jointEnable = ($urandom_range(0, 5) != 0);
            ticks(int'($urandom_range(1, 30)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
